// File: rtl/prefetch_buffer_pkg.sv
// rtl/prefetch_buffer_pkg.sv - shared types and constants for the instruction prefetch buffer
package prefetch_buffer_pkg;

   localparam int INSTRUCTION_BYTES = 4;

   typedef struct packed {
      logic [31:0] instruction;
      logic [31:0] programCounter;
   } fetchBufferEntry_;

   // DRAIN means stale responses from before a redirect are still owed by memory
   typedef enum logic {
      STREAM = 1'b0,
      DRAIN  = 1'b1
   } prefetchState_;

endpackage

// File: rtl/prefetch_buffer_if.sv
// rtl/prefetch_buffer_if.sv - memory, fetch and redirect signals of the prefetch buffer
interface prefetch_buffer_if;

   logic        redirectValid;
   logic [31:0] redirectAddress;
   logic        memoryRequest;
   logic        memoryReady;
   logic [31:0] memoryAddress;
   logic        memoryDataValid;
   logic [31:0] memoryData;
   logic        instructionValid;
   logic [31:0] instructionData;
   logic [31:0] instructionPC;
   logic        fetchReady;

   modport master (
      input  redirectValid, redirectAddress, memoryReady, memoryDataValid, memoryData, fetchReady,
      output memoryRequest, memoryAddress, instructionValid, instructionData, instructionPC
   );

   modport slave (
      output redirectValid, redirectAddress, memoryReady, memoryDataValid, memoryData, fetchReady,
      input  memoryRequest, memoryAddress, instructionValid, instructionData, instructionPC
   );

endinterface

// File: rtl/prefetch_buffer_fetch_fifo.sv
// rtl/prefetch_buffer_fetch_fifo.sv - synchronous FIFO of instruction/PC entries with flush
module fetch_fifo
   import prefetch_buffer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  fetchBufferEntry_         pushEntry,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output fetchBufferEntry_         head
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   fetchBufferEntry_ storage [DEPTH];
   logic [AW-1:0]    readPtr;
   logic [AW-1:0]    writePtr;
   logic             doPush;
   logic             doPop;

   assign full   = (count == FULL_COUNT);
   assign empty  = (count == '0);
   assign doPush = push && !full && !flush;
   assign doPop  = pop && !empty && !flush;
   assign head   = storage[readPtr];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         readPtr  <= '0;
         writePtr <= '0;
         count    <= '0;
      end else if (flush) begin
         readPtr  <= '0;
         writePtr <= '0;
         count    <= '0;
      end else begin
         if (doPush) writePtr <= writePtr + 1'b1;
         if (doPop)  readPtr  <= readPtr + 1'b1;
         count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
      end
   end

   always_ff @(posedge clock) begin
      if (doPush) storage[writePtr] <= pushEntry;
   end

endmodule

// File: rtl/prefetch_buffer.sv
// rtl/prefetch_buffer.sv - sequential instruction prefetch with credit-limited issue and redirect flush
module prefetch_buffer
   import prefetch_buffer_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                clock,
   input  logic                reset,
   prefetch_buffer_if.master   bus
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] CREDIT_LIMIT = (CW+1)'(DEPTH);

   prefetchState_    state;
   prefetchState_    stateNext;
   logic [CW-1:0]    occupancy;
   logic [CW-1:0]    outstanding;
   logic [CW-1:0]    discard;
   logic [CW-1:0]    staleCount;
   logic [CW:0]      creditUsed;
   logic [31:0]      requestPC;
   logic [31:0]      responsePC;
   logic [31:0]      alignedRedirect;
   logic             issueFire;
   logic             responseAccepted;
   logic             fifoPush;
   logic             fifoFull;
   logic             fifoEmpty;
   logic             dropResponse;
   fetchBufferEntry_ headEntry;
   fetchBufferEntry_ newEntry;

   // Buffered entries plus in-flight requests never exceed DEPTH, so a response always has room
   assign creditUsed        = {1'b0, occupancy} + {1'b0, outstanding};
   assign bus.memoryRequest = !reset && !bus.redirectValid && (creditUsed < CREDIT_LIMIT);
   assign bus.memoryAddress = requestPC;
   assign issueFire         = bus.memoryRequest && bus.memoryReady;
   assign responseAccepted  = bus.memoryDataValid && (outstanding != '0);
   assign staleCount        = outstanding - CW'(responseAccepted);
   assign alignedRedirect   = {bus.redirectAddress[31:2], 2'b00};
   assign newEntry          = '{instruction: bus.memoryData, programCounter: responsePC};

   always_comb begin
      stateNext    = state;
      fifoPush     = 1'b0;
      dropResponse = 1'b0;
      if (bus.redirectValid) begin
         stateNext = (staleCount != '0) ? DRAIN : STREAM;
      end else begin
         case (state)
            STREAM: fifoPush = responseAccepted && !fifoFull;
            DRAIN: begin
               dropResponse = responseAccepted;
               if (responseAccepted && discard == CW'(1)) stateNext = STREAM;
            end
            default: stateNext = STREAM;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= STREAM;
      else       state <= stateNext;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         requestPC   <= RESET_PC;
         responsePC  <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
      end else if (bus.redirectValid) begin
         requestPC   <= alignedRedirect;
         responsePC  <= alignedRedirect;
         outstanding <= staleCount;
         discard     <= staleCount;
      end else begin
         if (issueFire)    requestPC  <= requestPC + 32'(INSTRUCTION_BYTES);
         if (fifoPush)     responsePC <= responsePC + 32'(INSTRUCTION_BYTES);
         if (dropResponse) discard    <= discard - 1'b1;
         outstanding <= outstanding + CW'(issueFire) - CW'(responseAccepted);
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (fifoPush),
      .pop       (bus.instructionValid && bus.fetchReady),
      .flush     (bus.redirectValid),
      .pushEntry (newEntry),
      .full      (fifoFull),
      .empty     (fifoEmpty),
      .count     (occupancy),
      .head      (headEntry)
   );

   assign bus.instructionValid = !fifoEmpty;
   assign bus.instructionData  = fifoEmpty ? 32'h0 : headEntry.instruction;
   assign bus.instructionPC    = fifoEmpty ? 32'h0 : headEntry.programCounter;

endmodule

// File: tb/tb_prefetch_buffer.sv
// tb/tb_prefetch_buffer.sv - randomized bench for prefetch_buffer against a queue-based reference model
module tb_prefetch_buffer;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   typedef struct {
      logic [31:0] addr;
      bit          stale;
      int          readyCycle;
   } flight_t;

   typedef struct {
      logic [31:0] data;
      logic [31:0] pc;
   } entry_t;

   logic clock = 1'b0;
   logic reset = 1'b1;

   prefetch_buffer_if bus ();

   prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;
   int cycle  = 0;

   flight_t     inflight[$];
   entry_t      buffered[$];
   logic [31:0] modelRequestPC;

   int redirectPct, readyPct, fetchPct, minLat, maxLat;
   bit forceRedirect;
   bit lastPop;
   int popCount;

   function automatic logic [31:0] memFn(input logic [31:0] addr);
      return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, observed, expected, cycle);
      end
   endtask

   task automatic driveIdle();
      bus.redirectValid   = 1'b0;
      bus.redirectAddress = 32'h0;
      bus.memoryReady     = 1'b0;
      bus.memoryDataValid = 1'b0;
      bus.memoryData      = 32'h0;
      bus.fetchReady      = 1'b0;
   endtask

   // Entered and left at a falling edge: drive, sample, check, advance the model
   task automatic stepCycle();
      bit      redirect, respond, expReq, fire, pop;
      flight_t resp;
      logic [31:0] target;
      redirect = forceRedirect || ($urandom_range(0, 99) < redirectPct);
      target   = $urandom();
      respond  = (inflight.size() != 0) && (inflight[0].readyCycle <= cycle);
      bus.redirectValid   = redirect;
      bus.redirectAddress = target;
      bus.memoryReady     = ($urandom_range(0, 99) < readyPct);
      bus.fetchReady      = ($urandom_range(0, 99) < fetchPct);
      bus.memoryDataValid = respond;
      bus.memoryData      = respond ? memFn(inflight[0].addr) : $urandom();
      #1;
      expReq = !redirect && (buffered.size() + inflight.size() < DEPTH);
      check("memoryRequest", {31'b0, bus.memoryRequest}, {31'b0, expReq});
      check("memoryAddress", bus.memoryAddress, modelRequestPC);
      check("instructionValid", {31'b0, bus.instructionValid}, {31'b0, buffered.size() != 0});
      if (buffered.size() != 0) begin
         check("instructionData", bus.instructionData, buffered[0].data);
         check("instructionPC", bus.instructionPC, buffered[0].pc);
      end
      lastPop = bus.instructionValid && bus.fetchReady;

      fire = expReq && bus.memoryReady;
      pop  = (buffered.size() != 0) && bus.fetchReady && !redirect;
      if (respond) resp = inflight.pop_front();
      if (redirect) begin
         buffered.delete();
         foreach (inflight[i]) inflight[i].stale = 1'b1;
         modelRequestPC = {target[31:2], 2'b00};
      end else begin
         if (pop) void'(buffered.pop_front());
         if (respond && !resp.stale) buffered.push_back('{data: memFn(resp.addr), pc: resp.addr});
         if (fire) begin
            inflight.push_back('{addr: modelRequestPC, stale: 1'b0,
                                 readyCycle: cycle + $urandom_range(minLat, maxLat)});
            modelRequestPC = modelRequestPC + 32'd4;
         end
      end
      @(posedge clock);
      cycle++;
      @(negedge clock);
   endtask

   task automatic setKnobs(input int rd, input int rdy, input int fr, input int lo, input int hi);
      redirectPct = rd;
      readyPct    = rdy;
      fetchPct    = fr;
      minLat      = lo;
      maxLat      = hi;
   endtask

   initial begin
      driveIdle();
      forceRedirect  = 1'b0;
      modelRequestPC = RESET_PC;
      setKnobs(0, 100, 100, 1, 1);
      repeat (2) @(posedge clock);
      @(negedge clock);
      #1;
      check("reset memoryRequest", {31'b0, bus.memoryRequest}, 32'd0);
      check("reset memoryAddress", bus.memoryAddress, RESET_PC);
      check("reset instructionValid", {31'b0, bus.instructionValid}, 32'd0);
      check("reset instructionData", bus.instructionData, 32'h0);
      check("reset instructionPC", bus.instructionPC, 32'h0);
      @(negedge clock);
      reset = 1'b0;

      // Streaming at one instruction per cycle once the pipe is primed
      repeat (2) stepCycle();
      popCount = 0;
      repeat (20) begin
         stepCycle();
         if (lastPop) popCount++;
      end
      check("throughput pops", popCount, 32'd20);

      // Fetch stalled: credits cap the queue, then drain
      setKnobs(0, 100, 0, 1, 1);
      repeat (10) stepCycle();
      setKnobs(0, 100, 100, 1, 1);
      repeat (10) stepCycle();

      // Long latency with redirects, including back-to-back ones
      setKnobs(10, 80, 70, 3, 3);
      repeat (300) stepCycle();
      setKnobs(40, 90, 60, 1, 4);
      repeat (200) stepCycle();

      // Memory back-pressure
      setKnobs(5, 20, 80, 1, 2);
      repeat (300) stepCycle();

      // Fill three entries after a fresh redirect, then reset mid-stream
      setKnobs(0, 100, 0, 1, 1);
      forceRedirect = 1'b1;
      stepCycle();
      forceRedirect = 1'b0;
      for (int k = 0; k < 50 && buffered.size() != 3; k++) stepCycle();
      check("fill to three entries", buffered.size(), 32'd3);
      driveIdle();
      reset = 1'b1;
      #1;
      check("midreset instructionValid", {31'b0, bus.instructionValid}, 32'd0);
      check("midreset memoryAddress", bus.memoryAddress, RESET_PC);
      check("midreset memoryRequest", {31'b0, bus.memoryRequest}, 32'd0);
      buffered.delete();
      inflight.delete();
      modelRequestPC = RESET_PC;
      @(posedge clock);
      cycle++;
      @(negedge clock);
      reset = 1'b0;

      setKnobs(8, 70, 70, 1, 3);
      repeat (400) stepCycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/prefetch_buffer.md
Name: prefetch_buffer

Overview:
Instruction prefetch queue that sits between instruction memory and the Fetch stage. It issues sequential word requests to memory ahead of Fetch and allows several requests in flight. Returned instructions are buffered in-order with their program counters. On a redirect (branch or trap) it flushes its contents and discards stale in-flight responses.

Parameters:
DEPTH, 4, number of buffer entries; also the cap on entries plus in-flight requests (power of two, at least 2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
redirectValid  input  1  flush and restart fetch at redirectAddress
redirectAddress  input  32  new fetch address; bits [1:0] ignored (treated as 0)
memoryRequest  output  1  request valid towards instruction memory
memoryReady  input  1  memory accepts request this cycle
memoryAddress  output  32  word-aligned request address
memoryDataValid  input  1  in-order response strobe
memoryData  input  32  response instruction word
instructionValid  output  1  buffer head valid towards Fetch
instructionData  output  32  head instruction
instructionPC  output  32  head program counter
fetchReady  input  1  Fetch consumes head this cycle

Behaviour:
- Reset values:
  - memoryRequest=0, memoryAddress=RESET_PC, instructionValid=0, instructionData=0, instructionPC=0.
  - Internal state: requestPC=RESET_PC, responsePC=RESET_PC, occupancy=0, outstanding=0, discard=0, FIFO pointers=0.
- Issue:
  - memoryRequest = !redirectValid && (occupancy + outstanding < DEPTH).
  - memoryAddress = requestPC.
  - Handshake fires when memoryRequest && memoryReady. It increments outstanding and sets requestPC += 4; requestPC wraps modulo 2^32.
  - memoryRequest may deassert without memoryReady having been seen.
- Response (memoryDataValid, no redirect this cycle):
  - outstanding decrements.
  - If discard > 0: discard decrements and the word is dropped.
  - Otherwise push {memoryData, responsePC} and set responsePC += 4.
  - A response with outstanding == 0 is a protocol error: ignore it; the verification bench flags it.
- Output:
  - instructionValid = (occupancy != 0); data and PC come from the FIFO head.
  - Pop when instructionValid && fetchReady.
  - A push in cycle N is visible at the head no earlier than cycle N+1.
  - Simultaneous push and pop leave occupancy unchanged.
- Full: push while full cannot occur by construction. The verification bench asserts occupancy + outstanding <= DEPTH.
- Redirect (highest priority):
  - occupancy <= 0 and FIFO pointers reset; any pop this cycle is ignored.
  - requestPC <= redirectAddress and responsePC <= redirectAddress, both with bits [1:0] cleared.
  - discard <= outstanding - (memoryDataValid ? 1 : 0); a response arriving in the redirect cycle is dropped.
  - outstanding <= the same value as discard.
  - No request is issued in the redirect cycle; issue resumes the next cycle.
  - Back-to-back redirects: the latest wins.
- State machine, two states:
  - STREAM: discard == 0.
  - DRAIN: discard > 0.
  - STREAM->DRAIN on a redirect with stale requests in flight; DRAIN->STREAM when the last stale response is dropped.
  - Requests continue in DRAIN, subject to the credit rule.
- Latency:
  - First memoryRequest in the first cycle after reset deasserts.
  - With single-cycle memory and fetchReady=1, sustained throughput is one instruction per cycle.
- Reset mid-operation clears everything immediately; in-flight responses after reset are not expected.
- Counter widths: occupancy and outstanding use $clog2(DEPTH)+1 bits.

Decomposition:
- Shared package pack:
  - typedef fetchBufferEntry_ {instruction[31:0], programCounter[31:0]}.
  - Localparam INSTRUCTION_BYTES=4.
  - Typedef for the STREAM/DRAIN state enum.
- Sub-module fetch_fifo: synchronous FIFO of fetchBufferEntry_.
  - Parameter DEPTH.
  - Ports: push, pop, flush, full, empty, count, head.
  - Async active-high reset.
- prefetch_buffer holds the PCs, the counters, the FSM and the credit logic.

Test Plan:
- Reset release, memoryReady=1, 1-cycle memory, fetchReady=1 -> requests to 0x0, 0x4, 0x8, …, one per cycle; instructionPC outputs 0x0, 0x4, 0x8 in order with matching data.
- fetchReady=0, DEPTH=4 -> exactly 4 handshakes then memoryRequest=0. Occupancy reaches 4. Raising fetchReady drains 0x0..0xC, then requests resume at 0x10.
- 3-cycle memory latency, 2 requests in flight (0x8, 0xC), redirect to 0x103 -> the two responses are dropped, the next request is 0x100, and the first output is instructionPC=0x100.
- Redirect in the same cycle as memoryDataValid, with pop and 1 other request in flight -> FIFO empty next cycle, discard=1, no stale PC ever reaches the output.
- memoryReady held low 5 cycles -> memoryAddress held stable at the pending PC, no PC skipped after memoryReady rises.
- Assert reset mid-stream with 3 entries buffered -> instructionValid=0 and memoryAddress=RESET_PC immediately; after release, the fetch sequence restarts at RESET_PC.
